// File: rtl/store_buffer.sv
// Word-granularity store buffer between the core data port and a single-port RAM.
// Stores queue in a circular FIFO and drain one per cycle while the port has no load; loads forward the youngest match.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              empty,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - 2;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic             full;
  logic             enq;
  logic             drain;
  logic [TAG_W-1:0] cpu_tag;
  logic [PTR_W-1:0] idx;
  logic             unused_addr_bits;

  assign cpu_tag          = cpu_addr[ADDR_W-1:2];
  assign unused_addr_bits = ^cpu_addr[31:ADDR_W];

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign enq   = cpu_we && !full && !rst;
  assign drain = !empty && !cpu_re && !rst;
  assign stall = cpu_we && full && !rst;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({enq, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: entry payload is not reset; the valid bits alone decide whether an entry means anything.
  always_ff @(posedge clk) begin
    if (enq) begin
      tag_q[tail_q]  <= cpu_tag;
      data_q[tail_q] <= cpu_wdata;
    end
  end

  // Loads own the port; otherwise the head entry is written out.
  always_comb begin
    ram_we    = 4'h0;
    ram_addr  = cpu_addr[ADDR_W-1:0];
    ram_wdata = data_q[head_q];
    if (drain) begin
      ram_we   = 4'hF;
      ram_addr = {tag_q[head_q], 2'b00};
    end
  end

  // Walk oldest to youngest so the last hit found is the youngest store.
  always_comb begin
    cpu_rdata = ram_rdata;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (cpu_re && valid_q[idx] && (tag_q[idx] == cpu_tag))
        cpu_rdata = data_q[idx];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected RAM writes and load data are queued by
// the stimulus tasks and popped by a negedge monitor whenever the DUT presents them.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        empty;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  store_buffer #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .empty     (empty),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] lq[$];
  logic        load_chk = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          n_writes = 0;
  int          stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every RAM write and every checked load is matched against the queues.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (ram_we != 4'h0) begin
        n_writes++;
        if (wq.size() == 0) begin
          check("unexpected_write", {28'h0, ram_we}, 32'h0);
        end else begin
          e = wq.pop_front();
          check("wr_we", {28'h0, ram_we}, 32'hF);
          check("wr_addr", {22'h0, ram_addr}, e.addr);
          check("wr_data", ram_wdata, e.data);
        end
      end
      if (load_chk) begin
        if (lq.size() == 0) begin
          check("load_no_expectation", 32'h1, 32'h0);
        end else begin
          check("load_data", cpu_rdata, lq.pop_front());
          check("load_no_drain", {28'h0, ram_we}, 32'h0);
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit expect_write);
    int n;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    if (expect_write) wq.push_back('{a, d});
    n = 0;
    @(negedge clk);
    while (stall && n < 50) begin
      stall_cycles++;
      n++;
      @(negedge clk);
    end
    if (stall) check("store_stall_timeout", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
  endtask

  // Leaves cpu_re high; the caller decides when to release the port.
  task automatic do_load(input logic [31:0] a, input logic [31:0] exp);
    cpu_re   = 1'b1;
    cpu_addr = a;
    lq.push_back(exp);
    load_chk = 1'b1;
    @(posedge clk);
    #1;
    load_chk = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    @(negedge clk);
    while (!empty && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_done_empty", {31'h0, empty}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] addrs [10] = '{32'h100, 32'h2A4, 32'h018, 32'h3F0, 32'h0C8,
                              32'h1D4, 32'h100, 32'h07C, 32'h2E0, 32'h354};

  initial begin
    int w0;
    rst       = 1'b1;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    ram_rdata = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_empty", {31'h0, empty}, 32'h1);
    check("reset_ram_we", {28'h0, ram_we}, 32'h0);
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_rdata", cpu_rdata, 32'h12345678);
    @(posedge clk);
    #1;

    // 1: single store drains the cycle after it is accepted
    do_store(32'h10, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("t1_ram_we", {28'h0, ram_we}, 32'hF);
    check("t1_ram_addr", {22'h0, ram_addr}, 32'h10);
    check("t1_ram_wdata", ram_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_empty", {31'h0, empty}, 32'h1);
    check("t1_ram_we_idle", {28'h0, ram_we}, 32'h0);
    @(posedge clk);
    #1;

    // 2: fill while loading, stall on the fifth store, release by draining
    cpu_re = 1'b1;
    w0 = n_writes;
    for (int i = 0; i < 4; i++) do_store(32'(i * 4), 32'(i + 1), 1'b1);
    @(negedge clk);
    check("t2_not_empty", {31'h0, empty}, 32'h0);
    check("t2_no_writes", 32'(n_writes - w0), 32'h0);
    @(posedge clk);
    #1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h14;
    cpu_wdata = 32'h5;
    wq.push_back('{32'h14, 32'h5});
    @(negedge clk);
    check("t2_stall_full", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (stall && n < 20) begin
        n++;
        @(negedge clk);
      end
      check("t2_stall_release", {31'h0, stall}, 32'h0);
    end
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    wait_drained();

    // 3: youngest of two matching entries is forwarded
    ram_rdata = 32'hBAD0BAD0;
    cpu_re = 1'b1;
    do_store(32'h20, 32'h11111111, 1'b1);
    do_store(32'h20, 32'h22222222, 1'b1);
    do_load(32'h20, 32'h22222222);
    cpu_re = 1'b0;
    wait_drained();

    // 4: load miss passes RAM data, load hit forwards, no drain during loads
    cpu_re = 1'b1;
    do_store(32'h30, 32'h33333333, 1'b1);
    ram_rdata = 32'hCAFEF00D;
    do_load(32'h34, 32'hCAFEF00D);
    do_load(32'h30, 32'h33333333);
    cpu_re = 1'b0;
    wait_drained();

    // 5: reset discards buffered stores, including the drain presented in the reset cycle
    cpu_re = 1'b1;
    do_store(32'h40, 32'h40404040, 1'b0);
    do_store(32'h44, 32'h44444444, 1'b0);
    do_store(32'h48, 32'h48484848, 1'b0);
    rst       = 1'b1;
    cpu_re    = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h4C;
    cpu_wdata = 32'h4C4C4C4C;
    @(negedge clk);
    check("t5_rst_ram_we", {28'h0, ram_we}, 32'h0);
    check("t5_rst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cpu_we = 1'b0;
    @(negedge clk);
    check("t5_empty", {31'h0, empty}, 32'h1);
    check("t5_ram_we", {28'h0, ram_we}, 32'h0);
    @(posedge clk);
    #1;
    ram_rdata = 32'h5A5A5A5A;
    do_load(32'h44, 32'h5A5A5A5A);
    cpu_re = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 6: ten stores with a load every third slot; order preserved across pointer wrap
    ram_rdata    = 32'h0BADF00D;
    stall_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 2) begin
        do_load(32'h3FC, 32'h0BADF00D);
        cpu_re = 1'b0;
      end
      do_store(addrs[i], 32'hA0000000 + 32'(i), 1'b1);
    end
    check("t6_no_stall", 32'(stall_cycles), 32'h0);
    wait_drained();

    repeat (2) @(posedge clk);
    check("writes_outstanding", 32'(wq.size()), 32'h0);
    check("loads_outstanding", 32'(lq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
